exec_muldiv: RTL

- Iterative multi-cycle multiply/divide unit for the RISC-V execute stage; implements the M/RV64M operations MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU and the W variants.
- Parametrised successor of the execute ALU's single `done` flag: full valid/ready handshake on both sides, flush, width parameter, and RISC-V-exact corner cases.
- The execute stage stalls on `in_ready`/`out_valid`; flush is driven by the pipeline on branch mispredict or exception.

---
 rtl/exec_muldiv.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/exec_muldiv.sv
// Iterative RISC-V M/RV64M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, valid/ready on both sides.
module exec_muldiv #(
   parameter int XLEN    = 64,
   parameter bit WORD_EN = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic            word,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int CW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
      logic signed [XLEN-1:0] t;
      t = x << (XLEN - 32);
      return t >>> (XLEN - 32);
   endfunction

   function automatic logic [XLEN-1:0] wfix(input logic [XLEN-1:0] x, input logic w);
      return w ? sext32(x) : x;
   endfunction

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      op_q, op_d;
   logic            word_q, word_d;
   logic            neg_q, neg_d;
   logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
   logic [XLEN-1:0] result_q, result_d;

   logic            word_eff, sgn_a, sgn_b, neg_a, neg_b, div_zero, ovf;
   logic [XLEN-1:0] ext_a, ext_b, mag_a, mag_b, min_w, spec_res;

   // Operand preparation for the accept cycle
   always_comb begin
      word_eff = word & WORD_EN & (op[2] | (op == 3'd0));
      sgn_a    = (op == 3'd1) | (op == 3'd2) | (op == 3'd4) | (op == 3'd6);
      sgn_b    = (op == 3'd1) | (op == 3'd4) | (op == 3'd6);
      ext_a    = a;
      ext_b    = b;
      if (word_eff) begin
         ext_a = sgn_a ? sext32(a) : XLEN'(a[31:0]);
         ext_b = sgn_b ? sext32(b) : XLEN'(b[31:0]);
      end
      neg_a    = sgn_a & ext_a[XLEN-1];
      neg_b    = sgn_b & ext_b[XLEN-1];
      mag_a    = neg_a ? -ext_a : ext_a;
      mag_b    = neg_b ? -ext_b : ext_b;
      min_w    = word_eff ? sext32(XLEN'(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}};
      div_zero = op[2] & (ext_b == '0);
      ovf      = op[2] & ~op[0] & (ext_a == min_w) & (ext_b == '1);
      if (div_zero)
         spec_res = op[1] ? wfix(ext_a, word_eff) : '1;
      else
         spec_res = op[1] ? '0 : ext_a;
   end

   logic [XLEN:0]   sum, sh;
   logic            ge;
   logic [XLEN-1:0] hi_n, lo_n, fin_res;

   // One multiply or divide iteration, then result formation on the last one
   always_comb begin
      sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
      sh  = {hi_q, lo_q[XLEN-1]};
      ge  = sh >= {1'b0, mcand_q};
      if (op_q[2]) begin
         hi_n = ge ? XLEN'(sh - {1'b0, mcand_q}) : sh[XLEN-1:0];
         lo_n = {lo_q[XLEN-2:0], ge};
      end else begin
         hi_n = sum[XLEN:1];
         lo_n = {sum[0], lo_q[XLEN-1:1]};
      end
      case (op_q)
         3'd0:                fin_res = word_q ? sext32(lo_n >> (XLEN - 32)) : lo_n;
         3'd1, 3'd2, 3'd3:    fin_res = neg_q ? XLEN'((-{hi_n, lo_n}) >> XLEN) : hi_n;
         3'd4, 3'd5:          fin_res = wfix(neg_q ? -lo_n : lo_n, word_q);
         default:             fin_res = wfix(neg_q ? -hi_n : hi_n, word_q);
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      word_d   = word_q;
      neg_d    = neg_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      mcand_d  = mcand_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (in_valid & ~flush) begin
               op_d    = op;
               word_d  = word_eff;
               neg_d   = (op[2] & op[1]) ? neg_a : (neg_a ^ neg_b);
               hi_d    = '0;
               lo_d    = op[2] ? (word_eff ? mag_a << (XLEN - 32) : mag_a) : mag_b;
               mcand_d = op[2] ? mag_b : mag_a;
               cnt_d   = word_eff ? CW'(32) : CW'(XLEN);
               if (div_zero | ovf) begin
                  state_d  = DONE;
                  result_d = spec_res;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            hi_d  = hi_n;
            lo_d  = lo_n;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d  = DONE;
               result_d = fin_res;
            end
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d  = IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         word_q   <= 1'b0;
         neg_q    <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         mcand_q  <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         word_q   <= word_d;
         neg_q    <= neg_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         mcand_q  <= mcand_d;
         result_q <= result_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign result    = result_q;

endmodule
